// File: rtl/uart_pkg.sv
// uart_pkg: shared UART receiver types, data width and baud divider helper.
package uart_pkg;
    localparam int UART_DATA_W = 8;
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, BREAK} rx_state_e;
    function automatic int uart_div(input int sys_clk_hz, input int baud, input int oversample);
        return sys_clk_hz / (baud * oversample);
    endfunction
endpackage

// File: rtl/uart_rx_oversample_if.sv
// uart_rx_oversample_if: raw RX line plus received byte and status pulses.
interface uart_rx_oversample_if;
    logic                              rx;
    logic [uart_pkg::UART_DATA_W-1:0]  dat;
    logic                              received_strobe;
    logic                              frame_err;
    logic                              parity_err;
    logic                              busy;
    modport master(input rx, output dat, received_strobe, frame_err, parity_err, busy);
    modport slave(output rx, input dat, received_strobe, frame_err, parity_err, busy);
endinterface

// File: rtl/uart_baud_tick.sv
// uart_baud_tick: DIV-cycle oversample tick generator with synchronous restart.
module uart_baud_tick #(
    parameter int DIV = 4
) (
    input  logic i_wb_clk,
    input  logic i_wb_rst_n,
    input  logic restart_i,
    output logic tick_o
);
    localparam int W = DIV > 1 ? $clog2(DIV) : 1;
    logic [W-1:0] cnt_q, cnt_d;
    always_comb begin
        tick_o = !restart_i && cnt_q == W'(DIV - 1);
        cnt_d  = (restart_i || tick_o) ? '0 : cnt_q + 1'b1;
    end
    always_ff @(posedge i_wb_clk or negedge i_wb_rst_n) begin
        if (!i_wb_rst_n)
            cnt_q <= '0;
        else
            cnt_q <= cnt_d;
    end
endmodule

// File: rtl/uart_rx_oversample.sv
// uart_rx_oversample: oversampling 8-bit UART receiver with framing checks.
// Optional even parity bit after D7 when UART_RX_PARITY_EN is defined.
module uart_rx_oversample
    import uart_pkg::*;
#(
    parameter int SYS_CLK_HZ = 12_000_000,
    parameter int BAUD       = 115200,
    parameter int OVERSAMPLE = 16
) (
    input logic                 i_wb_clk,
    input logic                 i_wb_rst_n,
    uart_rx_oversample_if.master rx_if
);
    localparam int DIV = uart_div(SYS_CLK_HZ, BAUD, OVERSAMPLE);
    localparam int TW  = $clog2(OVERSAMPLE);
    localparam logic [TW-1:0] C_LO  = TW'(OVERSAMPLE / 2 - 1);
    localparam logic [TW-1:0] C_MID = TW'(OVERSAMPLE / 2);
    localparam logic [TW-1:0] C_HI  = TW'(OVERSAMPLE / 2 + 1);
    localparam logic [TW-1:0] C_END = TW'(OVERSAMPLE - 1);

    if (DIV < 1 || OVERSAMPLE < 8 || OVERSAMPLE % 2 != 0) begin : g_cfg_chk
        $error("uart_rx_oversample: DIV must be >= 1 and OVERSAMPLE even and >= 8");
    end

    logic                   rx_meta_q, rx_s_q, rx_prev_q;
    logic [1:0]             flush_q;
    rx_state_e              state_q;
    logic [TW-1:0]          tc_q;
    logic [3:0]             bit_q;
    logic [1:0]             smp_q;
    logic [UART_DATA_W-1:0] shift_q, dat_q;
    logic                   strobe_q, ferr_q, busy_q;
    logic                   tick, start_edge, maj, at_dec, at_end;
`ifdef UART_RX_PARITY_EN
    logic                   par_bad_q, perr_q;
    assign rx_if.parity_err = perr_q;
`else
    assign rx_if.parity_err = 1'b0;
`endif

    // rx_prev_q only reflects the pin once the synchronizer has flushed its reset value,
    // so a line held low across reset release never looks like a start edge.
    assign start_edge = state_q == IDLE && rx_prev_q && !rx_s_q;
    assign maj        = (smp_q[0] & smp_q[1]) | (smp_q[0] & rx_s_q) | (smp_q[1] & rx_s_q);
    assign at_dec     = tick && tc_q == C_HI;
    assign at_end     = tick && tc_q == C_END;

    uart_baud_tick #(.DIV(DIV)) u_tick (
        .i_wb_clk  (i_wb_clk),
        .i_wb_rst_n(i_wb_rst_n),
        .restart_i (start_edge),
        .tick_o    (tick)
    );

    always_ff @(posedge i_wb_clk or negedge i_wb_rst_n) begin
        if (!i_wb_rst_n) begin
            rx_meta_q <= 1'b1;
            rx_s_q    <= 1'b1;
            rx_prev_q <= 1'b0;
            flush_q   <= '0;
            state_q   <= IDLE;
            tc_q      <= '0;
            bit_q     <= '0;
            smp_q     <= '0;
            shift_q   <= '0;
            dat_q     <= '0;
            strobe_q  <= 1'b0;
            ferr_q    <= 1'b0;
            busy_q    <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_bad_q <= 1'b0;
            perr_q    <= 1'b0;
`endif
        end else begin
            rx_meta_q <= rx_if.rx;
            rx_s_q    <= rx_meta_q;
            flush_q   <= {flush_q[0], 1'b1};
            rx_prev_q <= rx_s_q & flush_q[1];
            strobe_q  <= 1'b0;
            ferr_q    <= 1'b0;
`ifdef UART_RX_PARITY_EN
            perr_q    <= 1'b0;
`endif
            if (tick)
                tc_q <= tc_q + 1'b1;
            if (tick && tc_q == C_LO)
                smp_q[0] <= rx_s_q;
            if (tick && tc_q == C_MID)
                smp_q[1] <= rx_s_q;
            case (state_q)
                IDLE: begin
                    if (start_edge) begin
                        state_q <= START;
                        tc_q    <= '0;
                        busy_q  <= 1'b1;
                    end
                end
                START: begin
                    if (at_dec && maj) begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end else if (at_end) begin
                        state_q <= DATA;
                        bit_q   <= '0;
                    end
                end
                DATA: begin
                    if (at_dec) begin
                        shift_q <= {maj, shift_q[UART_DATA_W-1:1]};
                        bit_q   <= bit_q + 1'b1;
                    end
                    if (at_end && bit_q == 4'(UART_DATA_W)) begin
`ifdef UART_RX_PARITY_EN
                        state_q <= PARITY;
`else
                        state_q <= STOP;
`endif
                    end
                end
`ifdef UART_RX_PARITY_EN
                PARITY: begin
                    if (at_dec)
                        par_bad_q <= maj ^ (^shift_q);
                    if (at_end)
                        state_q <= STOP;
                end
`endif
                // Decide at the stop-bit centre so a back-to-back start edge is not missed.
                STOP: begin
                    if (at_dec) begin
                        if (!maj) begin
                            ferr_q  <= 1'b1;
                            state_q <= BREAK;
`ifdef UART_RX_PARITY_EN
                        end else if (par_bad_q) begin
                            perr_q  <= 1'b1;
                            state_q <= IDLE;
                            busy_q  <= 1'b0;
`endif
                        end else begin
                            dat_q    <= shift_q;
                            strobe_q <= 1'b1;
                            state_q  <= IDLE;
                            busy_q   <= 1'b0;
                        end
                    end
                end
                BREAK: begin
                    if (rx_s_q) begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign rx_if.dat             = dat_q;
    assign rx_if.received_strobe = strobe_q;
    assign rx_if.frame_err       = ferr_q;
    assign rx_if.busy            = busy_q;
endmodule

// File: tb/tb_uart_rx_oversample.sv
// tb_uart_rx_oversample: frame-level scoreboard bench for uart_rx_oversample.
// Parity scenario compiled in when UART_RX_PARITY_EN is defined.
module tb_uart_rx_oversample;
    localparam int BIT = 64;
`ifdef UART_RX_PARITY_EN
    localparam int NB = 11;
`else
    localparam int NB = 10;
`endif
    localparam int LAT_LO = (NB - 1) * BIT + 20;
    localparam int LAT_HI = (NB - 1) * BIT + 60;

    typedef struct {
        int         kind;
        logic [7:0] d;
        int         t0;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    int         cyc = 0;
    int         total = 0;
    int         bad = 0;
    int         n_strobe = 0;
    int         n_ferr = 0;
    int         n_perr = 0;
    logic [7:0] exp_dat = 8'h00;
    exp_t       q[$];
    exp_t       e_c;
    int         k_c;
    int         lat_c;

    uart_rx_oversample_if bus();

    uart_rx_oversample #(
        .SYS_CLK_HZ(7_372_800),
        .BAUD      (115200),
        .OVERSAMPLE(16)
    ) dut (
        .i_wb_clk  (clk),
        .i_wb_rst_n(rst_n),
        .rx_if     (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic wait_clks(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v);
        bus.rx = v;
        wait_clks(BIT);
    endtask

    // Expected outcome follows only from the frame contents: low stop -> framing error,
    // wrong parity -> parity error, otherwise the byte itself.
    task automatic send_frame(input logic [7:0] d, input logic stop, input logic par_flip);
        exp_t e;
        e.d  = d;
        e.t0 = cyc;
`ifdef UART_RX_PARITY_EN
        e.kind = !stop ? 1 : par_flip ? 2 : 0;
`else
        e.kind = !stop ? 1 : 0;
`endif
        q.push_back(e);
        drive(1'b0);
        for (int i = 0; i < 8; i++)
            drive(d[i]);
`ifdef UART_RX_PARITY_EN
        drive(^d ^ par_flip);
`else
        if (par_flip) drive(1'b1);
`endif
        drive(stop);
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            if (bus.received_strobe || bus.frame_err || bus.parity_err) begin
                k_c = bus.received_strobe ? 0 : bus.frame_err ? 1 : 2;
                n_strobe += int'(bus.received_strobe);
                n_ferr   += int'(bus.frame_err);
                n_perr   += int'(bus.parity_err);
                chk("one_pulse", $countones({bus.received_strobe, bus.frame_err, bus.parity_err}), 1);
                if (q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_pulse: got kind %0d want none (cycle %0d)", k_c, cyc);
                end else begin
                    e_c = q.pop_front();
                    chk("pulse_kind", k_c, e_c.kind);
                    if (k_c == 0) begin
                        chk("strobe_data", bus.dat, e_c.d);
                        exp_dat = e_c.d;
                    end
                    lat_c = cyc - e_c.t0;
                    total++;
                    if (lat_c < LAT_LO || lat_c > LAT_HI) begin
                        bad++;
                        $display("FAIL latency: got %0d want %0d..%0d", lat_c, LAT_LO, LAT_HI);
                    end
                end
            end
            chk("dat_hold", bus.dat, exp_dat);
        end
    end

    initial begin
        bus.rx = 1'b1;
        wait_clks(3);
        chk("rst_dat", bus.dat, 8'h00);
        chk("rst_strobe", bus.received_strobe, 0);
        chk("rst_ferr", bus.frame_err, 0);
        chk("rst_perr", bus.parity_err, 0);
        chk("rst_busy", bus.busy, 0);
        rst_n = 1'b1;
        wait_clks(50);
        send_frame(8'h61, 1'b1, 1'b0);
        wait_clks(100);
        chk("t1_dat", bus.dat, 8'h61);
        chk("t1_strobes", n_strobe, 1);
        send_frame(8'h30, 1'b1, 1'b0);
        send_frame(8'h46, 1'b1, 1'b0);
        wait_clks(100);
        chk("t2_dat", bus.dat, 8'h46);
        chk("t2_strobes", n_strobe, 3);
        bus.rx = 1'b0;
        wait_clks(10);
        chk("t3_busy_hi", bus.busy, 1);
        wait_clks(10);
        bus.rx = 1'b1;
        wait_clks(40);
        chk("t3_busy_lo", bus.busy, 0);
        wait_clks(100);
        chk("t3_strobes", n_strobe, 3);
        send_frame(8'h72, 1'b0, 1'b0);
        wait_clks(2000);
        chk("t4_busy_break", bus.busy, 1);
        bus.rx = 1'b1;
        wait_clks(200);
        chk("t4_ferr", n_ferr, 1);
        chk("t4_dat", bus.dat, 8'h46);
        chk("t4_strobes", n_strobe, 3);
        chk("t4_busy_lo", bus.busy, 0);
        drive(1'b0);
        for (int i = 0; i < 4; i++)
            drive(i != 3);
        bus.rx = 1'b1;
        wait_clks(32);
        rst_n = 1'b0;
        exp_dat = 8'h00;
        q.delete();
        wait_clks(2);
        chk("t5_rst_dat", bus.dat, 8'h00);
        chk("t5_rst_busy", bus.busy, 0);
        wait_clks(2);
        rst_n = 1'b1;
        wait_clks(100);
        send_frame(8'h2E, 1'b1, 1'b0);
        wait_clks(100);
        chk("t5_dat", bus.dat, 8'h2E);
        chk("t5_strobes", n_strobe, 4);
        rst_n = 1'b0;
        bus.rx = 1'b0;
        exp_dat = 8'h00;
        wait_clks(3);
        rst_n = 1'b1;
        wait_clks(200);
        chk("low_rel_busy", bus.busy, 0);
        bus.rx = 1'b1;
        wait_clks(100);
        chk("low_rel_strobes", n_strobe, 4);
        chk("low_rel_ferr", n_ferr, 1);
`ifdef UART_RX_PARITY_EN
        send_frame(8'h41, 1'b1, 1'b1);
        wait_clks(100);
        chk("t6_perr", n_perr, 1);
        chk("t6_dat_keep", bus.dat, 8'h00);
        send_frame(8'h41, 1'b1, 1'b0);
        wait_clks(100);
        chk("t6_dat", bus.dat, 8'h41);
        chk("t6_strobes", n_strobe, 5);
`else
        chk("noparity_perr", n_perr, 0);
`endif
        chk("queue_empty", q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
